// File: rtl/debounce_pkg.sv
// Shared types and defaults for the time-shared debounce controller.
package debounce_pkg;

    typedef enum logic {IDLE, SCAN} db_state_e;

    localparam int unsigned DB_TICK_DIV_DEF     = 1000;
    localparam int unsigned DB_STABLE_TICKS_DEF = 100;

    // The counter only has to reach STABLE_TICKS-1, but the +1 keeps STABLE_TICKS=1 at one bit.
    function automatic int unsigned db_cnt_w(input int unsigned stable);
        return $clog2(stable + 1);
    endfunction

endpackage

// File: rtl/db_tick_gen.sv
// Free-running divider: tick_out is high for one clk_in cycle every TICK_DIV cycles.
module db_tick_gen #(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic clk_in,
    input  logic rst_in,
    output logic tick_out
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_out = (cnt_q == LAST);

endmodule

// File: rtl/debounce_sched.sv
// Time-shared debounce controller: one tick divider and one update datapath scanned over N_CH.
// Optional sticky event flags with ev_clr_in / ev_sticky_out when DB_EVENT_LATCH_EN is defined.
module debounce_sched
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned TICK_DIV     = DB_TICK_DIV_DEF,
    parameter int unsigned STABLE_TICKS = DB_STABLE_TICKS_DEF,
    localparam int unsigned CNT_W       = db_cnt_w(STABLE_TICKS)
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic [N_CH-1:0] noisy_in,
    output logic [N_CH-1:0] clean_out,
    output logic [N_CH-1:0] rise_out,
    output logic [N_CH-1:0] fall_out,
`ifdef DB_EVENT_LATCH_EN
    input  logic [N_CH-1:0] ev_clr_in,
    output logic [N_CH-1:0] ev_sticky_out,
`endif
    output logic            scan_busy_out
);

    localparam int unsigned PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(N_CH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_TICKS - 1);

    // A tick arriving mid-scan would be lost, so the divider must outlast one full scan.
    if (TICK_DIV <= N_CH + 1) begin : g_bad_cfg
        $error("debounce_sched: TICK_DIV must exceed N_CH+1");
    end

    db_state_e                   state_q, state_d;
    logic [PTR_W-1:0]            ptr_q, ptr_d;
    logic [N_CH-1:0]             sync1_q, sync2_q;
    logic [N_CH-1:0]             clean_q, clean_d;
    logic [N_CH-1:0]             rise_q, rise_d;
    logic [N_CH-1:0]             fall_q, fall_d;
    logic [N_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic                        tick;
    logic                        slot_en;

    db_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .tick_out (tick)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SCAN;
                    ptr_d   = '0;
                end
            end
            SCAN: begin
                if (ptr_q == LAST_CH) begin
                    state_d = IDLE;
                end else begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        slot_en       = (state_q == SCAN);
        scan_busy_out = slot_en;
    end

    // Shared compare/update: only the channel under ptr_q moves; pulses default low each cycle.
    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        if (slot_en) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (ptr_q == PTR_W'(i)) begin
                    if (sync2_q[i] == clean_q[i]) begin
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        cnt_d[i]   = '0;
                        clean_d[i] = sync2_q[i];
                        rise_d[i]  = sync2_q[i];
                        fall_d[i]  = ~sync2_q[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sync1_q <= '0;
            sync2_q <= '0;
            clean_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= noisy_in;
            sync2_q <= sync1_q;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign clean_out = clean_q;
    assign rise_out  = rise_q;
    assign fall_out  = fall_q;

`ifdef DB_EVENT_LATCH_EN
    logic [N_CH-1:0] sticky_q, sticky_d;

    // Set is OR'd in after the clear so a coincident event is never lost.
    always_comb begin
        sticky_d = (sticky_q & ~ev_clr_in) | rise_q | fall_q;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign ev_sticky_out = sticky_q;
`endif

endmodule

// File: tb/tb_debounce_sched.sv
// Directed bench for debounce_sched (N_CH=4, TICK_DIV=8, STABLE_TICKS=3); cyc counts clocks since
// reset release, so channel i is updated on the posedge numbered 8k+1+i (k >= 1).
module tb_debounce_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] noisy = 4'h0;
    logic [3:0] clean, rise, fall;
    logic       busy;
    int         cyc;
    int         vectors = 0;
    int         errors = 0;
`ifdef DB_EVENT_LATCH_EN
    logic [3:0] ev_clr = 4'h0;
    logic [3:0] sticky;
`endif

    debounce_sched #(
        .N_CH         (4),
        .TICK_DIV     (8),
        .STABLE_TICKS (3)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst_n),
        .noisy_in      (noisy),
        .clean_out     (clean),
        .rise_out      (rise),
        .fall_out      (fall),
`ifdef DB_EVENT_LATCH_EN
        .ev_clr_in     (ev_clr),
        .ev_sticky_out (sticky),
`endif
        .scan_busy_out (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic goto(input int c);
        int guard;
        guard = 0;
        while (cyc < c && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic do_reset(input logic [3:0] nv);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        noisy = nv;
    endtask

    task automatic test_reset;
        logic exp_busy;
        @(negedge clk);
        rst_n = 1'b0;
        noisy = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({clean, rise, fall, busy} !== 13'h0) begin
                errors++;
                $display("FAIL reset_outputs: got clean=%h rise=%h fall=%h busy=%b want all 0",
                         clean, rise, fall, busy);
            end
        end
        noisy = 4'h0;
        rst_n = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            goto(c);
            exp_busy = (c >= 8) && ((c % 8) < 4);
            vectors++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL scan_busy c=%0d: got %b want %b", c, busy, exp_busy);
            end
        end
    endtask

    task automatic test_single_rise;
        logic [11:0] exp;
        do_reset(4'h1);
        for (int c = 1; c <= 27; c++) begin
            goto(c);
            exp = {(c >= 25) ? 4'h1 : 4'h0, (c == 25) ? 4'h1 : 4'h0, 4'h0};
            vectors++;
            if ({clean, rise, fall} !== exp) begin
                errors++;
                $display("FAIL single_rise c=%0d: got clean/rise/fall=%h want %h",
                         c, {clean, rise, fall}, exp);
            end
        end
    endtask

    task automatic test_glitch;
        do_reset(4'h0);
        for (int c = 1; c <= 40; c++) begin
            goto(c);
            vectors++;
            if ({clean, rise, fall} !== 12'h0) begin
                errors++;
                $display("FAIL glitch c=%0d: got clean/rise/fall=%h want 000",
                         c, {clean, rise, fall});
            end
            if (c >= 7 && c <= 10) noisy[1] = (c % 2 == 1);
        end
    endtask

    task automatic test_broken_run;
        logic [11:0] exp;
        do_reset(4'h0);
        for (int c = 1; c <= 56; c++) begin
            goto(c);
            exp = {(c >= 51) ? 4'h4 : 4'h0, (c == 51) ? 4'h4 : 4'h0, 4'h0};
            vectors++;
            if ({clean, rise, fall} !== exp) begin
                errors++;
                $display("FAIL broken_run c=%0d: got clean/rise/fall=%h want %h",
                         c, {clean, rise, fall}, exp);
            end
            case (c)
                4, 12, 28, 36, 44: noisy[2] = 1'b1;
                20:                noisy[2] = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp_c, exp_r;
        do_reset(4'hF);
        for (int c = 1; c <= 30; c++) begin
            goto(c);
            case (c)
                25:      begin exp_c = 4'h1; exp_r = 4'h1; end
                26:      begin exp_c = 4'h3; exp_r = 4'h2; end
                27:      begin exp_c = 4'h7; exp_r = 4'h4; end
                28:      begin exp_c = 4'hF; exp_r = 4'h8; end
                default: begin exp_c = (c > 28) ? 4'hF : 4'h0; exp_r = 4'h0; end
            endcase
            vectors++;
            if ({clean, rise, fall} !== {exp_c, exp_r, 4'h0}) begin
                errors++;
                $display("FAIL back_to_back c=%0d: got clean/rise/fall=%h want %h",
                         c, {clean, rise, fall}, {exp_c, exp_r, 4'h0});
            end
        end
    endtask

    task automatic test_reset_mid_scan;
        logic [11:0] exp;
        do_reset(4'h9);
        for (int c = 1; c <= 25; c++) begin
            goto(c);
            exp = {(c == 25) ? 4'h1 : 4'h0, (c == 25) ? 4'h1 : 4'h0, 4'h0};
            vectors++;
            if ({clean, rise, fall} !== exp) begin
                errors++;
                $display("FAIL pre_reset c=%0d: got clean/rise/fall=%h want %h",
                         c, {clean, rise, fall}, exp);
            end
        end
        vectors++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_scan_busy: got %b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({clean, rise, fall, busy} !== 13'h0) begin
            errors++;
            $display("FAIL async_reset: got clean=%h rise=%h fall=%h busy=%b want all 0",
                     clean, rise, fall, busy);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 29; c++) begin
            goto(c);
            if (c < 25)      exp = 12'h000;
            else if (c == 25) exp = {4'h1, 4'h1, 4'h0};
            else if (c < 28)  exp = {4'h1, 4'h0, 4'h0};
            else if (c == 28) exp = {4'h9, 4'h8, 4'h0};
            else              exp = {4'h9, 4'h0, 4'h0};
            vectors++;
            if ({clean, rise, fall} !== exp) begin
                errors++;
                $display("FAIL post_reset c=%0d: got clean/rise/fall=%h want %h",
                         c, {clean, rise, fall}, exp);
            end
        end
    endtask

`ifdef DB_EVENT_LATCH_EN
    task automatic test_sticky;
        do_reset(4'h1);
        ev_clr = 4'h0;
        for (int c = 1; c <= 30; c++) begin
            goto(c);
            vectors++;
            if (sticky !== ((c >= 26) ? 4'h1 : 4'h0)) begin
                errors++;
                $display("FAIL sticky_set c=%0d: got %h want %h", c, sticky,
                         (c >= 26) ? 4'h1 : 4'h0);
            end
        end
        ev_clr = 4'h1;
        goto(31);
        vectors++;
        if (sticky !== 4'h0) begin
            errors++;
            $display("FAIL sticky_clear: got %h want 0", sticky);
        end
        ev_clr = 4'h0;
        noisy = 4'h0;
        goto(57);
        vectors++;
        if ({fall, sticky} !== {4'h1, 4'h0}) begin
            errors++;
            $display("FAIL sticky_fall: got fall=%h sticky=%h want fall=1 sticky=0", fall, sticky);
        end
        ev_clr = 4'h1;
        goto(58);
        vectors++;
        if (sticky !== 4'h1) begin
            errors++;
            $display("FAIL sticky_set_wins: got %h want 1", sticky);
        end
        ev_clr = 4'h0;
        goto(59);
        vectors++;
        if (sticky !== 4'h1) begin
            errors++;
            $display("FAIL sticky_hold: got %h want 1", sticky);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_rise();
        test_glitch();
        test_broken_run();
        test_back_to_back();
        test_reset_mid_scan();
`ifdef DB_EVENT_LATCH_EN
        test_sticky();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/debounce_sched.md
Name: debounce_sched

Overview:
- Time-shared debounce controller for N_CH push-button or switch inputs.
- One sample-tick divider and one compare/update datapath serve all channels; a scan FSM steps through the channels round-robin, one channel per clock after each tick.
- Produces per-channel clean levels and one-cycle rise/fall event pulses for downstream control logic.
- Replaces N independent 20-bit debounce counters with N small tick counters.

Parameters:
- N_CH, 4, number of input channels (1..32).
- TICK_DIV, 1000, clk_in cycles per sample tick (10 us at 100 MHz); must be > N_CH+1.
- STABLE_TICKS, 100, consecutive differing samples required to flip clean_out (1 ms at defaults); must be >= 1.
- CNT_W, $clog2(STABLE_TICKS+1), width of per-channel stability counter (derived, not overridden).

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous, active-low reset.
- noisy_in  in  N_CH  raw asynchronous button inputs.
- clean_out  out  N_CH  debounced levels.
- rise_out  out  N_CH  one-cycle pulse when clean_out[i] goes 0->1.
- fall_out  out  N_CH  one-cycle pulse when clean_out[i] goes 1->0.
- scan_busy_out  out  1  high while the FSM is in SCAN.
- ev_clr_in  in  N_CH  clear mask for sticky events (present only with DB_EVENT_LATCH_EN).
- ev_sticky_out  out  N_CH  latched event flags (present only with DB_EVENT_LATCH_EN).

Behaviour:
- Reset (rst_in=0, async assert): all state is cleared.
  - Synchronizers, clean_out, rise_out, fall_out, stability counters, divider, ptr and scan_busy_out all go to 0.
  - FSM goes to IDLE.
  - Deassertion is taken on the clock; there is no internal reset synchronizer.
- Synchronizer: 2-flop per channel; sync[i] lags noisy_in[i] by 2 clocks.
- Divider: counts 0..TICK_DIV-1 and wraps; tick is high for one cycle when the count equals TICK_DIV-1. It free-runs in all FSM states.
- FSM states: IDLE, SCAN.
  - IDLE: on tick, ptr<=0 and go to SCAN; otherwise stay.
  - SCAN: process channel ptr this cycle. If ptr==N_CH-1, go to IDLE; else ptr<=ptr+1.
- Per-channel update (only when ptr selects the channel in SCAN):
  - If sync==clean_out: cnt<=0.
  - Else if cnt==STABLE_TICKS-1: clean_out flips, cnt<=0, and the matching rise_out/fall_out pulses high for exactly one clock (registered, asserted with the new clean_out value).
  - Else cnt<=cnt+1.
- Glitch rejection: any sample equal to clean_out restarts the count. A level must therefore differ on STABLE_TICKS consecutive ticks.
- Latency from a stable change on noisy_in to clean_out: 2 sync clocks + wait to the next tick + (STABLE_TICKS-1) further ticks + (ptr+1) clocks. Worst case is under (STABLE_TICKS+1)*TICK_DIV + N_CH + 2 clocks.
- Tick during SCAN cannot occur under the parameter rule. An elaboration-time check ($error) rejects TICK_DIV <= N_CH+1.
- Simultaneous events on several channels: each flips in its own scan slot, so pulses appear on consecutive clocks in channel order, never merged.
- Reset mid-SCAN: immediate return to IDLE with all outputs 0; no pulses are emitted on reset release.
- clean_out is never X after reset; it is invariant between scan slots.

Optional Feature:
- Macro: DB_EVENT_LATCH_EN.
- Defined:
  - ev_sticky_out[i] sets on rise_out[i] or fall_out[i].
  - It clears on ev_clr_in[i]; a set in the same cycle wins over clear.
  - Reset value is 0.
- Undefined: ev_clr_in and ev_sticky_out are absent from the port list; no latch logic is generated.

Decomposition:
- Package debounce_pkg holds:
  - typedef enum logic {IDLE, SCAN} db_state_e;
  - default constants DB_TICK_DIV_DEF=1000 and DB_STABLE_TICKS_DEF=100;
  - function db_cnt_w(stable) returning the counter width.
- Sub-module db_tick_gen: parameter TICK_DIV, ports clk_in, rst_in, tick_out. It is the natural split and is reusable by other timing blocks.
- The scan FSM and the per-channel register array stay in debounce_sched.

Test Plan (N_CH=4, TICK_DIV=8, STABLE_TICKS=3, 10 ns clock):
- Reset held 3 cycles with noisy_in=4'hF -> clean_out, rise_out, fall_out and scan_busy_out are 0 throughout reset. scan_busy_out is high for exactly 4 cycles after each tick.
- noisy_in[0] 0->1, held steady -> clean_out[0]=1 in the channel-0 slot of the 3rd tick after the sync delay. rise_out[0] is a single 1-cycle pulse; other channels stay unchanged.
- noisy_in[1] toggles every 10 ns for 40 ns, then returns to 0 -> clean_out[1] stays 0 and no pulses occur.
- noisy_in[2] high for 2 ticks, low 1 tick, high 3 ticks -> exactly one rise_out[2], asserted after the 3rd consecutive high sample only.
- noisy_in=4'hF together from 0 -> rise_out pulses on 4 consecutive clocks in order ch0..ch3; clean_out=4'hF.
- rst_in dropped mid-SCAN with channel 3 at cnt=2 -> all outputs 0 immediately. After release, a further 3 ticks are needed before clean_out[3] rises.
- With DB_EVENT_LATCH_EN: rise on ch0 -> ev_sticky_out=4'h1 held. ev_clr_in=4'h1 -> 0 next cycle. Clear coinciding with fall_out[0] -> stays 1.
